// File: rtl/aes_inv_ark_stage.sv
// Registered AddRoundKey stage of the iterative AES decryption datapath with round tagging and a
// 2-entry skid buffer. Optional per-byte parity output is enabled by defining ARK_PARITY_EN.
module aes_inv_ark_stage #(
  parameter int unsigned NR = 10,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_state,
  input  logic [127:0]  in_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_state,
  output logic [RW-1:0] out_round,
  output logic          out_mix,
  output logic          out_last
`ifdef ARK_PARITY_EN
  ,
  output logic [15:0]   out_parity
`endif
);

`ifdef ARK_PARITY_EN
  localparam int unsigned PW = 16;
`else
  localparam int unsigned PW = 0;
`endif
  // Buffer entry layout: {state, round, mix, last[, parity]}
  localparam int unsigned EW = 128 + RW + 2 + PW;

  logic [EW-1:0]  main_q, main_d, skid_q, skid_d, new_entry;
  logic           main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic           in_ready_q, in_ready_d;
  logic [RW-1:0]  cnt_q, cnt_d;
  logic [127:0]   ark_state;
  logic [RW-1:0]  tag_round;
  logic           tag_mix, tag_last;
  logic           in_xfer, out_xfer;

  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = main_vld_q & out_ready;
  assign ark_state = in_state ^ in_key;
  assign tag_round = RW'(NR) - cnt_q;
  assign tag_mix   = (tag_round != '0) && (tag_round != RW'(NR));
  assign tag_last  = (tag_round == '0);

`ifdef ARK_PARITY_EN
  logic [15:0] tag_parity;

  always_comb begin
    tag_parity = '0;
    for (int i = 0; i < 16; i++) begin
      tag_parity[15-i] = ^ark_state[127-8*i -: 8];
    end
  end

  assign new_entry  = {ark_state, tag_round, tag_mix, tag_last, tag_parity};
  assign out_parity = main_q[PW-1:0];
`else
  assign new_entry  = {ark_state, tag_round, tag_mix, tag_last};
`endif

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
      cnt_d      = '0;
    end else begin
      if (in_xfer) begin
        cnt_d = (cnt_q == RW'(NR)) ? '0 : cnt_q + RW'(1);
      end
      // in_ready is low whenever skid is full, so no input can collide with the skid refill.
      if (out_xfer && skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (!main_vld_q || out_xfer) begin
        main_vld_d = in_xfer;
        if (in_xfer) begin
          main_d = new_entry;
        end
      end else if (in_xfer) begin
        skid_vld_d = 1'b1;
        skid_d     = new_entry;
      end
    end
    in_ready_d = ~skid_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign out_state = main_q[EW-1 -: 128];
  assign out_round = main_q[EW-129 -: RW];
  assign out_mix   = main_q[PW+1];
  assign out_last  = main_q[PW];

endmodule

// File: tb/tb_aes_inv_ark_stage.sv
// Directed bench for aes_inv_ark_stage: table of vectors for a full block, plus hand-written
// back-pressure, flush and async-reset sequences.
module tb_aes_inv_ark_stage;

  localparam int unsigned NR = 10;
  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_state;
  logic [127:0]  in_key;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_state;
  logic [RW-1:0] out_round;
  logic          out_mix;
  logic          out_last;
`ifdef ARK_PARITY_EN
  logic [15:0]   out_parity;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  aes_inv_ark_stage #(.NR(NR), .RW(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .in_key     (in_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .out_round  (out_round),
    .out_mix    (out_mix),
    .out_last   (out_last)
`ifdef ARK_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  typedef struct {
    logic [127:0] state;
    logic [127:0] key;
    logic [127:0] exp_state;
    logic [3:0]   exp_round;
    logic         exp_mix;
    logic         exp_last;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [127:0] st, input logic [3:0] rnd,
                         input logic mix, input logic last);
    chk({name, ".valid"}, 128'(out_valid), 128'(1'b1));
    chk({name, ".state"}, out_state, st);
    chk({name, ".round"}, 128'(out_round), 128'(rnd));
    chk({name, ".mix"}, 128'(out_mix), 128'(mix));
    chk({name, ".last"}, 128'(out_last), 128'(last));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] st, input logic [127:0] k);
    in_valid = v;
    in_state = st;
    in_key   = k;
  endtask

  initial begin
    vecs[0]  = '{128'h00112233445566778899aabbccddeeff, 128'h13111d7fe3944a17f307a78b4d2b30c5,
                 128'h13003f4ca7c12c607b9e0d3081f6de3a, 4'd10, 1'b0, 1'b0};
    vecs[1]  = '{{16{8'ha5}}, {16{8'h0f}}, {16{8'haa}}, 4'd9, 1'b1, 1'b0};
    vecs[2]  = '{{16{8'hff}}, {16{8'hff}}, {16{8'h00}}, 4'd8, 1'b1, 1'b0};
    vecs[3]  = '{{16{8'h12}}, {16{8'h34}}, {16{8'h26}}, 4'd7, 1'b1, 1'b0};
    vecs[4]  = '{{16{8'hf0}}, {16{8'h0f}}, {16{8'hff}}, 4'd6, 1'b1, 1'b0};
    vecs[5]  = '{{16{8'h3c}}, {16{8'h81}}, {16{8'hbd}}, 4'd5, 1'b1, 1'b0};
    vecs[6]  = '{{16{8'h55}}, {16{8'haa}}, {16{8'hff}}, 4'd4, 1'b1, 1'b0};
    vecs[7]  = '{{16{8'h01}}, {16{8'h80}}, {16{8'h81}}, 4'd3, 1'b1, 1'b0};
    vecs[8]  = '{{16{8'hde}}, {16{8'had}}, {16{8'h73}}, 4'd2, 1'b1, 1'b0};
    vecs[9]  = '{{16{8'hbe}}, {16{8'hef}}, {16{8'h51}}, 4'd1, 1'b1, 1'b0};
    vecs[10] = '{{16{8'h77}}, {16{8'h88}}, {16{8'hff}}, 4'd0, 1'b0, 1'b1};
    vecs[11] = '{{16{8'h6b}}, {16{8'hb6}}, {16{8'hdd}}, 4'd10, 1'b0, 1'b0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0);
    #12;
    chk("rst.valid", 128'(out_valid), 128'(1'b0));
    chk("rst.ready", 128'(in_ready), 128'(1'b1));
    chk("rst.state", out_state, 128'h0);
    chk("rst.round", 128'(out_round), 128'h0);
    chk("rst.mix",   128'(out_mix), 128'h0);
    chk("rst.last",  128'(out_last), 128'h0);
    rst_n = 1'b1;
    tick();

    // Full block plus one, back to back
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].state, vecs[i].key);
      tick();
      chk_out($sformatf("blk%0d", i), vecs[i].exp_state, vecs[i].exp_round, vecs[i].exp_mix,
              vecs[i].exp_last);
      chk($sformatf("blk%0d.ready", i), 128'(in_ready), 128'(1'b1));
    end
    drive(1'b0, '0, '0);
    tick();
    chk("drain.valid", 128'(out_valid), 128'(1'b0));

    // Flush with empty buffer restarts the round count
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Back-pressure: two accepted, third stalled
    out_ready = 1'b0;
    drive(1'b1, {16{8'h11}}, {16{8'h22}});
    tick();
    chk("bp.ready1", 128'(in_ready), 128'(1'b1));
    drive(1'b1, {16{8'h44}}, {16{8'h88}});
    tick();
    chk("bp.ready2", 128'(in_ready), 128'(1'b0));
    drive(1'b1, {16{8'h0a}}, {16{8'ha0}});
    tick();
    chk("bp.ready3", 128'(in_ready), 128'(1'b0));
    chk_out("bp.hold", {16{8'h33}}, 4'd10, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk_out("bp.a", {16{8'h33}}, 4'd10, 1'b0, 1'b0);
    tick();
    chk_out("bp.b", {16{8'hcc}}, 4'd9, 1'b1, 1'b0);
    chk("bp.ready4", 128'(in_ready), 128'(1'b1));
    tick();
    chk_out("bp.c", {16{8'haa}}, 4'd8, 1'b1, 1'b0);
    drive(1'b0, '0, '0);
    tick();
    chk("bp.empty", 128'(out_valid), 128'(1'b0));

    // Flush with main and skid full and an input presented
    out_ready = 1'b0;
    drive(1'b1, {16{8'h01}}, {16{8'h02}});
    tick();
    drive(1'b1, {16{8'h04}}, {16{8'h08}});
    tick();
    chk("fl.full", 128'(in_ready), 128'(1'b0));
    flush = 1'b1;
    drive(1'b1, {16{8'h10}}, {16{8'h20}});
    tick();
    flush = 1'b0;
    chk("fl.valid", 128'(out_valid), 128'(1'b0));
    chk("fl.ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1;
    drive(1'b1, {16{8'hc0}}, {16{8'h0c}});
    tick();
    chk_out("fl.next", {16{8'hcc}}, 4'd10, 1'b0, 1'b0);

    // Async reset mid-block after four transfers
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, {16{8'h5a}}, {16{8'h00}});
      tick();
    end
    chk_out("ar.pre", {16{8'h5a}}, 4'd7, 1'b1, 1'b0);
    drive(1'b0, '0, '0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 128'(out_valid), 128'(1'b0));
    chk("ar.state", out_state, 128'h0);
    chk("ar.round", 128'(out_round), 128'h0);
    chk("ar.mix",   128'(out_mix), 128'h0);
    rst_n = 1'b1;
    drive(1'b1, {16{8'h0f}}, {16{8'hf0}});
    tick();
    chk_out("ar.next", {16{8'hff}}, 4'd10, 1'b0, 1'b0);

`ifdef ARK_PARITY_EN
    drive(1'b1, 128'h0, 128'h01000000000000000000000000000003);
    tick();
    chk("par", 128'(out_parity), 128'h8000);
`endif
    drive(1'b0, '0, '0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
